alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU for the pipelined CPU EX stage; successor to the 32-bit combinational ALU.
//  Adds a valid/ready handshake, one output register stage, shifts, and an optional iterative multiplier.
//  Keeps the 2-bit op encoding of the previous ALU in op[1:0] (NOR/SLT/ADD/SUB) and the same four flags.
// PARAMETERS
//  WIDTH  32  datapath width; power of 2, >=4. Internal localparam SHW = $clog2(WIDTH) (shift-amount width).
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block accepts an operation this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  op         in   3      000 NOR, 001 SLT, 010 ADD, 011 SUB, 100 MUL, 101 SLL, 110 SRL, 111 SRA
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes the result
//  result     out  WIDTH  operation result
//  carry_out  out  1      ADD: carry out of MSB; SUB: carry of a+~b+1 (1 = no borrow); else 0
//  zero       out  1      result == 0
//  overflow   out  1      ADD/SUB signed overflow; MUL: upper product half nonzero; else 0
//  negative   out  1      result[WIDTH-1]
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out_valid=0, in_ready=1, result=0, all flags 0; any multiply in flight is discarded.
//  - Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  - Single-cycle ops (all except MUL): result and flags are registered on the accept edge; out_valid=1 the next cycle (latency 1).
//  - Back-to-back: a new op accepted in the same cycle the old result drains (out_valid&&out_ready) -> out_valid stays 1, new result.
//  - Hold: while out_valid && !out_ready, result and flags are frozen and in_ready=0.
//  - out_valid drops the cycle after a drain with no new accept.
//  - SLT: signed compare, result = {0..,a<b}; a==b -> 0.
//  - NOR: ~(a|b).
//  - Shifts use b[SHW-1:0] only; higher bits of b are ignored.
//  - SRA replicates a[WIDTH-1]. Shift by 0 -> result = a.
//  - Arithmetic: ADD/SUB computed WIDTH+1 wide; overflow = (sign a == sign b') && (sign r != sign a), with b'=~b for SUB.
//  - FSM: IDLE -> MUL on accept of op 100 (when enabled); MUL -> IDLE after WIDTH iterations, loading the output regs.
//  - MUL is a shift-and-add over WIDTH cycles: accept at cycle 0, out_valid=1 at cycle WIDTH.
//  - MUL result: unsigned low WIDTH bits of a*b; in_ready=0 throughout MUL.
//  - Multiplicand/multiplier are latched at accept; input changes during MUL are ignored.
//  - Simultaneous reset and accept: reset wins, the op is lost.
// CONFIGURATION
//  ALU_PIPE_MUL_EN defined: op 100 = iterative multiply as above; MUL state and 2*WIDTH accumulator are present.
//  ALU_PIPE_MUL_EN undefined: no MUL state/accumulator. Op 100 is a 1-cycle op: result=0, zero=1, other flags 0.
// TESTING (WIDTH=32)
//  1) ADD a=7FFFFFFF b=00000001, out_ready=1 -> next cycle result=80000000, ov=1, neg=1, carry=0, zero=0.
//  2) SUB a=80000000 b=00000001 -> 7FFFFFFF, ov=1, carry=1. SUB a=00000DEF b=00000ABC -> 00000333, ov=0.
//  3) SLT a=0000000A b=FFFFFFFE -> 0. SLT a=0000000A b=00000105 -> 1.
//     SLT a=b=80000000 -> 0, zero=1. SRA a=80000000 b=4 -> F8000000, neg=1.
//  4) Backpressure: accept ADD 00000DEF+00000ABC, hold out_ready=0 for 3 cycles -> result 000018AB stable, in_ready=0.
//     Assert out_ready with a new NOR queued -> next cycle result=NOR value, out_valid never drops.
//  5) MUL_EN: MUL a=00010000 b=00010000 -> out_valid exactly 32 cycles after accept, result=0, zero=1, ov=1.
//     Without macro -> out_valid after 1 cycle, result=0, zero=1, ov=0.
//  6) Reset at cycle 10 of MUL a=3 b=5 -> out_valid=0, in_ready=1 immediately.
//     Next ADD 1+1 -> result=00000002 after 1 cycle.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered EX-stage ALU with valid/ready handshake
// Optional iterative shift-and-add multiplier enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, idle, load_alu;

  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt   = b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'b000: alu_res = ~(a | b);
      3'b001: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b010: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b101:  alu_res = a << shamt;
      3'b110:  alu_res = a >> shamt;
      3'b111:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  assign idle     = (state_q == IDLE);
  assign load_alu = accept && (op != 3'b100);
`else
  assign idle     = 1'b1;
  assign load_alu = accept;
`endif

  assign in_ready = idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      result_d    = alu_res;
      carry_d     = alu_c;
      ovf_d       = alu_v;
      zero_d      = (alu_res == '0);
      neg_d       = alu_res[WIDTH-1];
      out_valid_d = 1'b1;
    end
`ifdef ALU_PIPE_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // First partial product is folded into the accept edge so WIDTH iterations end at cycle WIDTH
    if (accept && (op == 3'b100)) begin
      state_d  = MUL;
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      cnt_d    = '0;
    end
    if (state_q == MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == SHW'(WIDTH-2)) begin
        state_d     = IDLE;
        result_d    = acc_step[WIDTH-1:0];
        carry_d     = 1'b0;
        ovf_d       = |acc_step[2*WIDTH-1:WIDTH];
        zero_d      = (acc_step[WIDTH-1:0] == '0);
        neg_d       = acc_step[WIDTH-1];
        out_valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
endmodule
